ub_port_schedule_ctrl: RTL and testbench

- Initiator side of a unified-buffer port. Walks a 3-deep affine loop nest and drives a buffer port's enable (wen or ren) and its `ctrl_vars[2:0]` bus at a fixed start delay and initiation interval.
- Also emits a data-valid strobe delayed by the port's read latency, so the consumer knows when returned read data is valid.
- One instance per buffer port.
- Sits between the top-level schedule/start logic and a `*_ub` port.

---
 rtl/ub_port_schedule_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ub_port_schedule_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_port_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ub_port_schedule_ctrl
// Description : Initiator side of a unified-buffer port. Walks a 3-deep
//               affine loop nest (var1 innermost, then var2, then var0) and
//               issues one port enable per point at a fixed start delay and
//               initiation interval. A READ_LAT-deep copy of the enable tells
//               the consumer when returned read data is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module ub_port_schedule_ctrl #(
    parameter int CW          = 16,
    parameter int EXT0        = 1,
    parameter int EXT2        = 64,
    parameter int EXT1        = 64,
    parameter int START_DELAY = 0,
    parameter int II          = 1,
    parameter int READ_LAT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    output logic            en,
    output logic [3*CW-1:0] ctrl_vars,
    output logic            data_valid,
    output logic            last,
    output logic            done,
    output logic            busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DELAY = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int              c_IIW      = (II > 1) ? $clog2(II) : 1;
    localparam logic [c_IIW-1:0] c_II_LAST = c_IIW'(II - 1);
    localparam logic [c_IIW-1:0] c_II_ONE  = c_IIW'(1);

    localparam logic [CW-1:0] c_V0_LAST = CW'(EXT0 - 1);
    localparam logic [CW-1:0] c_V1_LAST = CW'(EXT1 - 1);
    localparam logic [CW-1:0] c_V2_LAST = CW'(EXT2 - 1);
    localparam logic [CW-1:0] c_V_ONE   = CW'(1);

    // The first RUN cycle must land START_DELAY cycles after the flush cycle.
    // Leaving the flush takes one cycle and the dly==0 cycle takes another, so
    // the countdown is preloaded with START_DELAY-2. Delays of 0 and 1 both
    // go straight to RUN, which already is the cycle after flush.
    localparam bit          c_USE_DELAY = (START_DELAY >= 2);
    localparam logic [15:0] c_DLY_LOAD  = c_USE_DELAY ? 16'(START_DELAY - 2) : 16'd0;

    // ------------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------------
    generate
        if (II < 1) begin : g_bad_ii
            $error("ub_port_schedule_ctrl: II must be >= 1");
        end
        if (EXT0 < 1 || EXT1 < 1 || EXT2 < 1) begin : g_bad_ext
            $error("ub_port_schedule_ctrl: every extent must be >= 1");
        end
        if (START_DELAY < 0 || START_DELAY > 65535) begin : g_bad_delay
            $error("ub_port_schedule_ctrl: START_DELAY out of range 0..65535");
        end
        if (READ_LAT < 0 || READ_LAT > 8) begin : g_bad_lat
            $error("ub_port_schedule_ctrl: READ_LAT out of range 0..8");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [15:0]      r_dly;
    logic [c_IIW-1:0] r_ii;
    logic [CW-1:0]    r_var0;
    logic [CW-1:0]    r_var1;
    logic [CW-1:0]    r_var2;
    logic             r_done;

    logic w_issue;
    logic w_v1_wrap;
    logic w_v2_wrap;
    logic w_v0_wrap;
    logic w_last;

    // Issue slot is open on ii==0 in RUN; a stall simply skips the slot.
    assign w_issue   = (r_state == c_ST_RUN) && (r_ii == '0) && !stall;
    assign w_v1_wrap = (r_var1 == c_V1_LAST);
    assign w_v2_wrap = (r_var2 == c_V2_LAST);
    assign w_v0_wrap = (r_var0 == c_V0_LAST);
    assign w_last    = w_issue && w_v0_wrap && w_v2_wrap && w_v1_wrap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = c_ST_IDLE;
            c_ST_DELAY: if (r_dly == '0) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (w_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_DONE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = c_USE_DELAY ? c_ST_DELAY : c_ST_RUN;
        end
    end

    // Start-delay countdown; stall has no effect here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly <= 16'd0;
        end else if (flush) begin
            r_dly <= c_DLY_LOAD;
        end else if (r_state == c_ST_DELAY && r_dly != 16'd0) begin
            r_dly <= r_dly - 16'd1;
        end
    end

    // Initiation-interval counter, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ii <= '0;
        end else if (flush) begin
            r_ii <= '0;
        end else if (r_state == c_ST_RUN && !stall) begin
            r_ii <= (r_ii == c_II_LAST) ? '0 : r_ii + c_II_ONE;
        end
    end

    // Loop-nest counters; they always hold the next point to be issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_var0 <= '0;
            r_var1 <= '0;
            r_var2 <= '0;
        end else if (flush) begin
            r_var0 <= '0;
            r_var1 <= '0;
            r_var2 <= '0;
        end else if (w_issue) begin
            if (w_last) begin
                r_var0 <= '0;
                r_var1 <= '0;
                r_var2 <= '0;
            end else if (w_v1_wrap) begin
                r_var1 <= '0;
                if (w_v2_wrap) begin
                    r_var2 <= '0;
                    r_var0 <= r_var0 + c_V_ONE;
                end else begin
                    r_var2 <= r_var2 + c_V_ONE;
                end
            end else begin
                r_var1 <= r_var1 + c_V_ONE;
            end
        end
    end

    // Sticky completion flag, cleared only by flush or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (flush) begin
            r_done <= 1'b0;
        end else if (w_last) begin
            r_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Data-valid delay line (not flushed: in-flight reads must still report)
    // ------------------------------------------------------------------------
    generate
        if (READ_LAT == 0) begin : g_dv_comb
            assign data_valid = w_issue;
        end else if (READ_LAT == 1) begin : g_dv_one
            logic r_dv;
            // Single-stage delay of the issue strobe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dv <= 1'b0;
                end else begin
                    r_dv <= w_issue;
                end
            end
            assign data_valid = r_dv;
        end else begin : g_dv_pipe
            logic [READ_LAT-1:0] r_dv_pipe;
            // Multi-stage shift of the issue strobe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dv_pipe <= '0;
                end else begin
                    r_dv_pipe <= {r_dv_pipe[READ_LAT-2:0], w_issue};
                end
            end
            assign data_valid = r_dv_pipe[READ_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign en        = w_issue;
    assign last      = w_last;
    assign done      = r_done;
    assign busy      = (r_state == c_ST_DELAY) || (r_state == c_ST_RUN);
    assign ctrl_vars = {r_var2, r_var1, r_var0};

endmodule
`default_nettype wire

// File: tb/tb_ub_port_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ub_port_schedule_ctrl
// Description : Directed self-checking bench for ub_port_schedule_ctrl.
//               Four instances cover the default nest, a delayed/II=3 nest,
//               a nest that wraps var0, and the single-point corner case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ub_port_schedule_ctrl;

    localparam int c_MAXC = 4200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  flush_v;
    logic [3:0]  stall_v;
    wire  [3:0]  en_v;
    wire  [3:0]  dv_v;
    wire  [3:0]  last_v;
    wire  [3:0]  done_v;
    wire  [3:0]  busy_v;
    wire  [47:0] vars_v [0:3];

    int tests_run    = 0;
    int tests_failed = 0;

    // Scenario results
    int    sc_bad;
    int    sc_issues;
    int    sc_first_bad;
    string sc_what;
    logic        rec_en   [0:c_MAXC-1];
    logic        rec_last [0:c_MAXC-1];
    logic        rec_done [0:c_MAXC-1];
    logic        rec_busy [0:c_MAXC-1];
    logic        rec_dv   [0:c_MAXC-1];
    logic [47:0] rec_vars [0:c_MAXC-1];
    bit          hist     [0:c_MAXC-1];

    always #5 clk = ~clk;

    ub_port_schedule_ctrl #(.CW(16), .EXT0(1), .EXT2(64), .EXT1(64),
                            .START_DELAY(0), .II(1), .READ_LAT(1)) u_def (
        .clk(clk), .rst(rst), .flush(flush_v[0]), .stall(stall_v[0]),
        .en(en_v[0]), .ctrl_vars(vars_v[0]), .data_valid(dv_v[0]),
        .last(last_v[0]), .done(done_v[0]), .busy(busy_v[0]));

    ub_port_schedule_ctrl #(.CW(16), .EXT0(1), .EXT2(2), .EXT1(4),
                            .START_DELAY(5), .II(3), .READ_LAT(2)) u_sd (
        .clk(clk), .rst(rst), .flush(flush_v[1]), .stall(stall_v[1]),
        .en(en_v[1]), .ctrl_vars(vars_v[1]), .data_valid(dv_v[1]),
        .last(last_v[1]), .done(done_v[1]), .busy(busy_v[1]));

    ub_port_schedule_ctrl #(.CW(16), .EXT0(2), .EXT2(3), .EXT1(2),
                            .START_DELAY(1), .II(2), .READ_LAT(3)) u_e0 (
        .clk(clk), .rst(rst), .flush(flush_v[2]), .stall(stall_v[2]),
        .en(en_v[2]), .ctrl_vars(vars_v[2]), .data_valid(dv_v[2]),
        .last(last_v[2]), .done(done_v[2]), .busy(busy_v[2]));

    ub_port_schedule_ctrl #(.CW(16), .EXT0(1), .EXT2(1), .EXT1(1),
                            .START_DELAY(0), .II(1), .READ_LAT(0)) u_one (
        .clk(clk), .rst(rst), .flush(flush_v[3]), .stall(stall_v[3]),
        .en(en_v[3]), .ctrl_vars(vars_v[3]), .data_valid(dv_v[3]),
        .last(last_v[3]), .done(done_v[3]), .busy(busy_v[3]));

    // Point k of the nest as {var2, var1, var0}, var1 innermost
    function automatic logic [47:0] point(input int k, input int e1, input int e2);
        int v0, v1, v2;
        v1 = k % e1;
        v2 = (k / e1) % e2;
        v0 = k / (e1 * e2);
        return {16'(v2), 16'(v1), 16'(v0)};
    endfunction

    // Flush at cycle 0, run ncyc cycles, record outputs and count model mismatches.
    // Optional stall window [s_lo, s_hi] and optional second flush at cycle fl2.
    task automatic run_scenario(input int idx, input int e0, input int e1, input int e2,
                                input int sd, input int ii_n, input int rl, input int ncyc,
                                input int s_lo, input int s_hi, input int fl2);
        int n, fl_c, issued, iic, start_off;
        bit done_m, act, in_dly, ex_en, ex_last, ex_dv, stl;
        logic [47:0] ex_vars;
        n = e0 * e1 * e2;
        start_off = (sd < 1) ? 1 : sd;
        fl_c = 0; issued = 0; iic = 0; done_m = 1'b0;
        sc_bad = 0; sc_issues = 0; sc_first_bad = -1; sc_what = "none";
        for (int c = 0; c < c_MAXC; c++) begin
            rec_en[c] = 1'b0; rec_last[c] = 1'b0; rec_done[c] = 1'b0;
            rec_busy[c] = 1'b0; rec_dv[c] = 1'b0; rec_vars[c] = '0; hist[c] = 1'b0;
        end
        @(posedge clk); #1;
        flush_v[idx] = 1'b1;
        stall_v[idx] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            flush_v[idx] = (c == fl2);
            stl = (c >= s_lo) && (c <= s_hi);
            stall_v[idx] = stl;
            @(negedge clk);
            act     = (c >= fl_c + start_off) && (issued < n);
            in_dly  = (c < fl_c + start_off);
            ex_en   = act && (iic == 0) && !stl;
            ex_vars = (issued < n) ? point(issued, e1, e2) : 48'd0;
            ex_last = ex_en && (issued == n - 1);
            hist[c] = ex_en;
            ex_dv   = (c - rl >= 1) ? hist[c - rl] : 1'b0;
            rec_en[c] = en_v[idx]; rec_last[c] = last_v[idx]; rec_done[c] = done_v[idx];
            rec_busy[c] = busy_v[idx]; rec_dv[c] = dv_v[idx]; rec_vars[c] = vars_v[idx];
            if (en_v[idx] === 1'b1) sc_issues++;
            if (en_v[idx] !== ex_en || last_v[idx] !== ex_last || done_v[idx] !== done_m ||
                busy_v[idx] !== (act || in_dly) || dv_v[idx] !== ex_dv || vars_v[idx] !== ex_vars) begin
                if (sc_first_bad < 0) begin
                    sc_first_bad = c;
                    $sformat(sc_what, "en=%b/%b last=%b/%b done=%b/%b busy=%b/%b dv=%b/%b vars=%h/%h",
                             en_v[idx], ex_en, last_v[idx], ex_last, done_v[idx], done_m,
                             busy_v[idx], act || in_dly, dv_v[idx], ex_dv, vars_v[idx], ex_vars);
                end
                sc_bad++;
            end
            if (c == fl2) begin
                fl_c = c; issued = 0; iic = 0; done_m = 1'b0;
            end else if (act && !stl) begin
                if (ex_en) begin
                    issued++;
                    if (issued == n) done_m = 1'b1;
                end
                iic = (iic + 1) % ii_n;
            end
        end
        @(posedge clk); #1;
        flush_v[idx] = 1'b0;
        stall_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({en_v[i], last_v[i], done_v[i], busy_v[i], dv_v[i], vars_v[i]} !== 53'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got en=%b last=%b done=%b busy=%b dv=%b vars=%h, expected all zero",
                         i, en_v[i], last_v[i], done_v[i], busy_v[i], dv_v[i], vars_v[i]);
            end
        end
    endtask

    task automatic test_defaults();
        run_scenario(0, 1, 64, 64, 0, 1, 1, 4100, -1, -1, -1);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL defaults_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if (sc_issues !== 4096) begin tests_failed++;
            $display("FAIL defaults_issues: got %0d, expected 4096", sc_issues); end
        tests_run++;
        if ({rec_en[1], rec_vars[1]} !== {1'b1, 48'h0}) begin tests_failed++;
            $display("FAIL defaults_cycle1: got en=%b vars=%h, expected en=1 vars=0", rec_en[1], rec_vars[1]); end
        tests_run++;
        if (rec_vars[65] !== 48'h0001_0000_0000) begin tests_failed++;
            $display("FAIL defaults_cycle65: got %h, expected 000100000000", rec_vars[65]); end
        tests_run++;
        if ({rec_en[4096], rec_last[4096], rec_vars[4096]} !== {2'b11, 48'h003F_003F_0000}) begin tests_failed++;
            $display("FAIL defaults_last: got en=%b last=%b vars=%h, expected 1 1 003f003f0000",
                     rec_en[4096], rec_last[4096], rec_vars[4096]); end
        tests_run++;
        if ({rec_done[4096], rec_done[4097], rec_en[4097]} !== 3'b010) begin tests_failed++;
            $display("FAIL defaults_done: got done4096=%b done4097=%b en4097=%b, expected 0 1 0",
                     rec_done[4096], rec_done[4097], rec_en[4097]); end
        tests_run++;
        if ({rec_dv[1], rec_dv[2], rec_dv[4097], rec_dv[4098]} !== 4'b0110) begin tests_failed++;
            $display("FAIL defaults_data_valid: got %b%b%b%b, expected 0110",
                     rec_dv[1], rec_dv[2], rec_dv[4097], rec_dv[4098]); end
    endtask

    task automatic test_stall();
        run_scenario(0, 1, 64, 64, 0, 1, 1, 4103, 10, 12, -1);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL stall_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if ({rec_en[9], rec_en[10], rec_en[11], rec_en[12]} !== 4'b1000) begin tests_failed++;
            $display("FAIL stall_en_gap: got %b%b%b%b, expected 1000", rec_en[9], rec_en[10], rec_en[11], rec_en[12]); end
        tests_run++;
        if ({rec_en[13], rec_vars[13]} !== {1'b1, 48'h0000_0009_0000}) begin tests_failed++;
            $display("FAIL stall_retry: got en=%b vars=%h, expected 1 000000090000", rec_en[13], rec_vars[13]); end
        tests_run++;
        if (sc_issues !== 4096) begin tests_failed++;
            $display("FAIL stall_issues: got %0d, expected 4096", sc_issues); end
        tests_run++;
        if ({rec_last[4099], rec_done[4099], rec_done[4100]} !== 3'b101) begin tests_failed++;
            $display("FAIL stall_done_delay: got last=%b done4099=%b done4100=%b, expected 1 0 1",
                     rec_last[4099], rec_done[4099], rec_done[4100]); end
    endtask

    task automatic test_delay_ii();
        run_scenario(1, 1, 4, 2, 5, 3, 2, 32, 2, 3, -1);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL delay_ii_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if (sc_issues !== 8) begin tests_failed++;
            $display("FAIL delay_ii_issues: got %0d, expected 8", sc_issues); end
        tests_run++;
        if ({rec_busy[1], rec_en[4], rec_en[5], rec_en[8]} !== 4'b1011) begin tests_failed++;
            $display("FAIL delay_ii_first: got busy1=%b en4=%b en5=%b en8=%b, expected 1 0 1 1",
                     rec_busy[1], rec_en[4], rec_en[5], rec_en[8]); end
        tests_run++;
        if (rec_vars[6] !== 48'h0000_0001_0000) begin tests_failed++;
            $display("FAIL delay_ii_hold_next: got %h, expected 000000010000", rec_vars[6]); end
        tests_run++;
        if ({rec_last[26], rec_busy[27], rec_done[27], rec_dv[28]} !== 4'b1011) begin tests_failed++;
            $display("FAIL delay_ii_end: got last26=%b busy27=%b done27=%b dv28=%b, expected 1 0 1 1",
                     rec_last[26], rec_busy[27], rec_done[27], rec_dv[28]); end
    endtask

    task automatic test_var0_wrap();
        run_scenario(2, 2, 2, 3, 1, 2, 3, 28, -1, -1, -1);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL var0_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if (sc_issues !== 12) begin tests_failed++;
            $display("FAIL var0_issues: got %0d, expected 12", sc_issues); end
        tests_run++;
        if ({rec_vars[11], rec_vars[13]} !== {48'h0002_0001_0000, 48'h0000_0000_0001}) begin tests_failed++;
            $display("FAIL var0_wrap: got c11=%h c13=%h, expected 000200010000 000000000001", rec_vars[11], rec_vars[13]); end
        tests_run++;
        if ({rec_last[23], rec_done[24], rec_dv[25], rec_dv[26]} !== 4'b1101) begin tests_failed++;
            $display("FAIL var0_end: got last23=%b done24=%b dv25=%b dv26=%b, expected 1 1 0 1",
                     rec_last[23], rec_done[24], rec_dv[25], rec_dv[26]); end
    endtask

    task automatic test_restart();
        run_scenario(1, 1, 4, 2, 5, 3, 2, 32, -1, -1, 8);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL restart_delay_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if ({rec_en[8], rec_busy[9], rec_en[9], rec_dv[10], rec_en[13], rec_vars[13]} !== {5'b11011, 48'h0}) begin tests_failed++;
            $display("FAIL restart_inflight: got en8=%b busy9=%b en9=%b dv10=%b en13=%b vars13=%h, expected 1 1 0 1 1 0",
                     rec_en[8], rec_busy[9], rec_en[9], rec_dv[10], rec_en[13], rec_vars[13]); end
        run_scenario(0, 1, 64, 64, 0, 1, 1, 40, -1, -1, 18);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL restart_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if (rec_vars[18] !== 48'h0000_0011_0000) begin tests_failed++;
            $display("FAIL restart_at_var1_17: got %h, expected 000000110000", rec_vars[18]); end
        tests_run++;
        if ({rec_en[19], rec_done[19], rec_dv[19], rec_vars[19], rec_vars[20]} !== {3'b101, 48'h0, 48'h0000_0001_0000}) begin
            tests_failed++;
            $display("FAIL restart_cleared: got en=%b done=%b dv=%b vars19=%h vars20=%h, expected 1 0 1 0 000000010000",
                     rec_en[19], rec_done[19], rec_dv[19], rec_vars[19], rec_vars[20]); end
    endtask

    task automatic test_single();
        run_scenario(3, 1, 1, 1, 0, 1, 0, 6, -1, -1, 1);
        tests_run++;
        if (sc_bad !== 0) begin tests_failed++;
            $display("FAIL single_model: %0d bad cycles, first %0d (got/exp %s), expected 0", sc_bad, sc_first_bad, sc_what); end
        tests_run++;
        if ({rec_en[1], rec_last[1], rec_dv[1]} !== 3'b111) begin tests_failed++;
            $display("FAIL single_first: got en=%b last=%b dv=%b, expected 1 1 1", rec_en[1], rec_last[1], rec_dv[1]); end
        tests_run++;
        if ({rec_en[2], rec_last[2], rec_done[2], rec_busy[2]} !== 4'b1101) begin tests_failed++;
            $display("FAIL single_flush_wins: got en=%b last=%b done=%b busy=%b, expected 1 1 0 1",
                     rec_en[2], rec_last[2], rec_done[2], rec_busy[2]); end
        tests_run++;
        if ({rec_done[3], rec_busy[3], rec_en[3]} !== 3'b100) begin tests_failed++;
            $display("FAIL single_done: got done=%b busy=%b en=%b, expected 1 0 0", rec_done[3], rec_busy[3], rec_en[3]); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        tests_run++;
        if ({busy_v[0], en_v[0], dv_v[0], done_v[3]} !== 4'b1111) begin tests_failed++;
            $display("FAIL areset_pre: got busy=%b en=%b dv=%b one_done=%b, expected 1 1 1 1",
                     busy_v[0], en_v[0], dv_v[0], done_v[3]); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({en_v[0], last_v[0], done_v[0], busy_v[0], dv_v[0], vars_v[0], done_v[3]} !== 54'd0) begin tests_failed++;
            $display("FAIL areset_immediate: got en=%b last=%b done=%b busy=%b dv=%b vars=%h one_done=%b, expected all zero",
                     en_v[0], last_v[0], done_v[0], busy_v[0], dv_v[0], vars_v[0], done_v[3]); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({en_v[0], busy_v[0], done_v[0], dv_v[0]} !== 4'b0000) begin tests_failed++;
                $display("FAIL areset_idle[%0d]: got en=%b busy=%b done=%b dv=%b, expected 0 0 0 0",
                         c, en_v[0], busy_v[0], done_v[0], dv_v[0]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        flush_v = 4'b0;
        stall_v = 4'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_defaults();
        test_stall();
        test_var0_wrap();
        test_delay_ii();
        test_restart();
        test_single();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
